// File: rtl/rf_pkg.sv
// rf_pkg -- shared definitions for the register-file read stage.
//   SEL1_* : operand-1 source encodings (RF[rj], pc, zero, reserved counter ID)
//   SEL2_* : operand-2 source encodings (RF[rk], imm, cnt low word, cnt high word)
//   reg_addr_t : 5-bit architectural register address
//   NREG       : number of architectural registers
package rf_pkg;

  localparam int NREG = 32;

  typedef logic [4:0] reg_addr_t;

  localparam logic [1:0] SEL1_RF   = 2'd0;
  localparam logic [1:0] SEL1_PC   = 2'd1;
  localparam logic [1:0] SEL1_ZERO = 2'd2;
  localparam logic [1:0] SEL1_RSVD = 2'd3;

  localparam logic [1:0] SEL2_RF    = 2'd0;
  localparam logic [1:0] SEL2_IMM   = 2'd1;
  localparam logic [1:0] SEL2_CNTLO = 2'd2;
  localparam logic [1:0] SEL2_CNTHI = 2'd3;

endpackage

// File: rtl/rf_array.sv
// rf_array -- 32 x XLEN register storage.
//   clk             : clock
//   wb_en/addr/data : NUM_WB write ports, higher index wins on equal address
//   rd_addr/rd_data : NUM_RD asynchronous read ports; r0 always reads 0
// The array is intentionally not reset.
module rf_array
  import rf_pkg::*;
#(
  parameter int NUM_WB = 2,
  parameter int NUM_RD = 4,
  parameter int XLEN   = 32
) (
  input  logic                     clk,
  input  logic [NUM_WB-1:0]        wb_en,
  input  logic [5*NUM_WB-1:0]      wb_addr,
  input  logic [XLEN*NUM_WB-1:0]   wb_data,
  input  logic [5*NUM_RD-1:0]      rd_addr,
  output logic [XLEN*NUM_RD-1:0]   rd_data
);

  logic [XLEN-1:0] mem_q [NREG];

  // Write ports in ascending order so the last (youngest) port's NBA wins.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_en[p] && (wb_addr[p*5 +: 5] != 5'd0)) begin
        mem_q[wb_addr[p*5 +: 5]] <= wb_data[p*XLEN +: XLEN];
      end
    end
  end

  // Asynchronous reads with r0 hard-wired to zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_addr[i*5 +: 5] == 5'd0) begin
        rd_data[i*XLEN +: XLEN] = '0;
      end else begin
        rd_data[i*XLEN +: XLEN] = mem_q[rd_addr[i*5 +: 5]];
      end
    end
  end

endmodule

// File: rtl/rf_read_stage.sv
// rf_read_stage -- register read / operand select pipeline stage.
//   clk, rstn            : clock, async active-low reset
//   wb_en/addr/data      : write-back ports (higher index = younger)
//   in_valid/in_ready    : input bundle handshake; in_lane_en per-lane valid
//   in_uop..in_sel2, cnt : per-lane payload and counter value
//   out_valid/out_ready  : output handshake; out_lane_en per-lane valid
//   out_uop..out_op2     : registered per-lane payload and operands
//   flush                : drop held bundle and the one offered this cycle
// Build option: define RF_BYPASS_EN to forward same-cycle write data into
// capture-cycle reads. Held operands are refreshed from write-back in both builds.
module rf_read_stage
  import rf_pkg::*;
#(
  parameter int NUM_LANE = 2,
  parameter int NUM_WB   = 2,
  parameter int XLEN     = 32,
  parameter int UOP_W    = 64
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_WB-1:0]         wb_en,
  input  logic [5*NUM_WB-1:0]       wb_addr,
  input  logic [XLEN*NUM_WB-1:0]    wb_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_LANE-1:0]       in_lane_en,
  input  logic [UOP_W*NUM_LANE-1:0] in_uop,
  input  logic [5*NUM_LANE-1:0]     in_rd,
  input  logic [5*NUM_LANE-1:0]     in_rj,
  input  logic [5*NUM_LANE-1:0]     in_rk,
  input  logic [32*NUM_LANE-1:0]    in_pc,
  input  logic [XLEN*NUM_LANE-1:0]  in_imm,
  input  logic [2*NUM_LANE-1:0]     in_sel1,
  input  logic [2*NUM_LANE-1:0]     in_sel2,
  input  logic [63:0]               cnt,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_LANE-1:0]       out_lane_en,
  output logic [UOP_W*NUM_LANE-1:0] out_uop,
  output logic [5*NUM_LANE-1:0]     out_rd,
  output logic [5*NUM_LANE-1:0]     out_rj,
  output logic [5*NUM_LANE-1:0]     out_rk,
  output logic [32*NUM_LANE-1:0]    out_pc,
  output logic [XLEN*NUM_LANE-1:0]  out_imm,
  output logic [XLEN*NUM_LANE-1:0]  out_op1,
  output logic [XLEN*NUM_LANE-1:0]  out_op2
);

  localparam int NUM_RD = 2 * NUM_LANE;

  // Overlay the youngest matching write-back onto a value; r0 never matches.
  function automatic logic [XLEN-1:0] wb_merge(
    input reg_addr_t                a,
    input logic [XLEN-1:0]          v,
    input logic [NUM_WB-1:0]        en,
    input logic [5*NUM_WB-1:0]      ad,
    input logic [XLEN*NUM_WB-1:0]   dt
  );
    logic [XLEN-1:0] r;
    r = v;
    for (int p = 0; p < NUM_WB; p++) begin
      if (en[p] && (ad[p*5 +: 5] == a) && (a != 5'd0)) begin
        r = dt[p*XLEN +: XLEN];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] sel_op1(
    input logic [1:0] s, input logic [XLEN-1:0] rf, input logic [31:0] pc
  );
    case (s)
      SEL1_RF:  sel_op1 = rf;
      SEL1_PC:  sel_op1 = XLEN'(pc);
      default:  sel_op1 = '0;   // SEL1_ZERO and reserved counter ID
    endcase
  endfunction

  function automatic logic [XLEN-1:0] sel_op2(
    input logic [1:0] s, input logic [XLEN-1:0] rf, input logic [XLEN-1:0] imm,
    input logic [63:0] c
  );
    case (s)
      SEL2_RF:    sel_op2 = rf;
      SEL2_IMM:   sel_op2 = imm;
      SEL2_CNTLO: sel_op2 = XLEN'(c[31:0]);
      SEL2_CNTHI: sel_op2 = XLEN'(c[63:32]);
      default:    sel_op2 = '0;
    endcase
  endfunction

  logic [5*NUM_RD-1:0]    rd_addr_s;
  logic [XLEN*NUM_RD-1:0] rd_data_s;
  logic [XLEN-1:0]        src1_s [NUM_LANE];
  logic [XLEN-1:0]        src2_s [NUM_LANE];
  logic                   accept_s;
  logic                   hold_s;

  logic                      valid_q,   valid_d;
  logic [NUM_LANE-1:0]       lane_en_q, lane_en_d;
  logic [UOP_W*NUM_LANE-1:0] uop_q,     uop_d;
  logic [5*NUM_LANE-1:0]     rd_q,      rd_d;
  logic [5*NUM_LANE-1:0]     rj_q,      rj_d;
  logic [5*NUM_LANE-1:0]     rk_q,      rk_d;
  logic [32*NUM_LANE-1:0]    pc_q,      pc_d;
  logic [XLEN*NUM_LANE-1:0]  imm_q,     imm_d;
  logic [2*NUM_LANE-1:0]     sel1_q,    sel1_d;
  logic [2*NUM_LANE-1:0]     sel2_q,    sel2_d;
  logic [XLEN*NUM_LANE-1:0]  op1_q,     op1_d;
  logic [XLEN*NUM_LANE-1:0]  op2_q,     op2_d;

  rf_array #(.NUM_WB(NUM_WB), .NUM_RD(NUM_RD), .XLEN(XLEN)) u_rf_array (
    .clk     (clk),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept_s = in_valid && in_ready && !flush;
  assign hold_s   = valid_q && !out_ready;

  // Read ports: even = lane rj, odd = lane rk; optional same-cycle forwarding.
  always_comb begin
    rd_addr_s = '0;
    for (int l = 0; l < NUM_LANE; l++) begin
      rd_addr_s[(2*l)*5 +: 5]   = in_rj[l*5 +: 5];
      rd_addr_s[(2*l+1)*5 +: 5] = in_rk[l*5 +: 5];
`ifdef RF_BYPASS_EN
      src1_s[l] = wb_merge(in_rj[l*5 +: 5], rd_data_s[(2*l)*XLEN +: XLEN],
                           wb_en, wb_addr, wb_data);
      src2_s[l] = wb_merge(in_rk[l*5 +: 5], rd_data_s[(2*l+1)*XLEN +: XLEN],
                           wb_en, wb_addr, wb_data);
`else
      src1_s[l] = rd_data_s[(2*l)*XLEN +: XLEN];
      src2_s[l] = rd_data_s[(2*l+1)*XLEN +: XLEN];
`endif
    end
  end

  // Next-state: handshake, bundle capture, and hold-time operand refresh.
  always_comb begin
    valid_d   = valid_q;
    lane_en_d = lane_en_q;
    uop_d     = uop_q;
    rd_d      = rd_q;
    rj_d      = rj_q;
    rk_d      = rk_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    sel1_d    = sel1_q;
    sel2_d    = sel2_q;
    op1_d     = op1_q;
    op2_d     = op2_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (accept_s) begin
      lane_en_d = in_lane_en;
      uop_d     = in_uop;
      rd_d      = in_rd;
      rj_d      = in_rj;
      rk_d      = in_rk;
      pc_d      = in_pc;
      imm_d     = in_imm;
      sel1_d    = in_sel1;
      sel2_d    = in_sel2;
      for (int l = 0; l < NUM_LANE; l++) begin
        op1_d[l*XLEN +: XLEN] = sel_op1(in_sel1[l*2 +: 2], src1_s[l], in_pc[l*32 +: 32]);
        op2_d[l*XLEN +: XLEN] = sel_op2(in_sel2[l*2 +: 2], src2_s[l],
                                        in_imm[l*XLEN +: XLEN], cnt);
      end
    end else if (hold_s) begin
      // Only operands that came from the RF track later write-backs.
      for (int l = 0; l < NUM_LANE; l++) begin
        if (sel1_q[l*2 +: 2] == SEL1_RF) begin
          op1_d[l*XLEN +: XLEN] = wb_merge(rj_q[l*5 +: 5], op1_q[l*XLEN +: XLEN],
                                           wb_en, wb_addr, wb_data);
        end else begin
          op1_d[l*XLEN +: XLEN] = op1_q[l*XLEN +: XLEN];
        end
        if (sel2_q[l*2 +: 2] == SEL2_RF) begin
          op2_d[l*XLEN +: XLEN] = wb_merge(rk_q[l*5 +: 5], op2_q[l*XLEN +: XLEN],
                                           wb_en, wb_addr, wb_data);
        end else begin
          op2_d[l*XLEN +: XLEN] = op2_q[l*XLEN +: XLEN];
        end
      end
    end else begin
      op1_d = op1_q;
      op2_d = op2_q;
    end
  end

  // Output register bank; reset clears handshake and all per-lane outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q   <= 1'b0;
      lane_en_q <= '0;
      uop_q     <= '0;
      rd_q      <= '0;
      rj_q      <= '0;
      rk_q      <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      sel1_q    <= '0;
      sel2_q    <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      lane_en_q <= lane_en_d;
      uop_q     <= uop_d;
      rd_q      <= rd_d;
      rj_q      <= rj_d;
      rk_q      <= rk_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      sel1_q    <= sel1_d;
      sel2_q    <= sel2_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_lane_en = lane_en_q;
  assign out_uop     = uop_q;
  assign out_rd      = rd_q;
  assign out_rj      = rj_q;
  assign out_rk      = rk_q;
  assign out_pc      = pc_q;
  assign out_imm     = imm_q;
  assign out_op1     = op1_q;
  assign out_op2     = op2_q;

endmodule

// File: tb/tb_rf_read_stage.sv
// tb_rf_read_stage -- directed stimulus with a scoreboard queue and an
// independent output monitor for rf_read_stage (defaults: 2 lanes, 2 WB, XLEN 32).
module tb_rf_read_stage;

  logic         clk;
  logic         rstn;
  logic [1:0]   wb_en;
  logic [9:0]   wb_addr;
  logic [63:0]  wb_data;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_lane_en;
  logic [127:0] in_uop;
  logic [9:0]   in_rd, in_rj, in_rk;
  logic [63:0]  in_pc, in_imm;
  logic [3:0]   in_sel1, in_sel2;
  logic [63:0]  cnt;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_lane_en;
  logic [127:0] out_uop;
  logic [9:0]   out_rd, out_rj, out_rk;
  logic [63:0]  out_pc, out_imm, out_op1, out_op2;

  typedef struct packed {
    logic [1:0]  en;
    logic [63:0] uop0;
    logic [31:0] op1_0;
    logic [31:0] op2_0;
    logic [31:0] op1_1;
    logic [31:0] op2_1;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] exp_r7_op2;

  rf_read_stage dut (
    .clk(clk), .rstn(rstn),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_lane_en(in_lane_en),
    .in_uop(in_uop), .in_rd(in_rd), .in_rj(in_rj), .in_rk(in_rk),
    .in_pc(in_pc), .in_imm(in_imm), .in_sel1(in_sel1), .in_sel2(in_sel2),
    .cnt(cnt), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_en(out_lane_en),
    .out_uop(out_uop), .out_rd(out_rd), .out_rj(out_rj), .out_rk(out_rk),
    .out_pc(out_pc), .out_imm(out_imm), .out_op1(out_op1), .out_op2(out_op2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Monitor: every transfer must match the oldest expected bundle.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_xfer: got uop %h, want no transfer", out_uop[63:0]);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("lane_en", {62'd0, out_lane_en}, {62'd0, e.en});
        chk("uop0", out_uop[63:0], e.uop0);
        if (e.en[0]) begin
          chk("op1_l0", {32'd0, out_op1[31:0]}, {32'd0, e.op1_0});
          chk("op2_l0", {32'd0, out_op2[31:0]}, {32'd0, e.op2_0});
        end
        if (e.en[1]) begin
          chk("op1_l1", {32'd0, out_op1[63:32]}, {32'd0, e.op1_1});
          chk("op2_l1", {32'd0, out_op2[63:32]}, {32'd0, e.op2_1});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wbset(input int p, input bit en, input logic [4:0] a, input logic [31:0] d);
    wb_en[p] = en;
    wb_addr[p*5 +: 5] = a;
    wb_data[p*32 +: 32] = d;
  endtask

  task automatic set_lane(input int l, input bit en, input logic [4:0] rj, input logic [4:0] rk,
                          input logic [1:0] s1, input logic [1:0] s2, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [63:0] uop);
    in_lane_en[l] = en;
    in_rj[l*5 +: 5] = rj;
    in_rk[l*5 +: 5] = rk;
    in_rd[l*5 +: 5] = 5'd1;
    in_sel1[l*2 +: 2] = s1;
    in_sel2[l*2 +: 2] = s2;
    in_pc[l*32 +: 32] = pc;
    in_imm[l*32 +: 32] = imm;
    in_uop[l*64 +: 64] = uop;
  endtask

  task automatic push(input logic [1:0] en, input logic [63:0] uop, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    exp_t e;
    e.en = en; e.uop0 = uop; e.op1_0 = a; e.op2_0 = b; e.op1_1 = c; e.op2_1 = d;
    q.push_back(e);
  endtask

  task automatic issue();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
`ifdef RF_BYPASS_EN
    exp_r7_op2 = 32'hB;
`else
    exp_r7_op2 = 32'h77;
`endif
    rstn = 1'b0; wb_en = 2'b00; wb_addr = 10'd0; wb_data = 64'd0;
    in_valid = 1'b0; in_lane_en = 2'b00; in_uop = 128'd0; in_rd = 10'd0;
    in_rj = 10'd0; in_rk = 10'd0; in_pc = 64'd0; in_imm = 64'd0;
    in_sel1 = 4'd0; in_sel2 = 4'd0; cnt = 64'h00000009_00000002;
    flush = 1'b0; out_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_lane_en", {62'd0, out_lane_en}, 64'd0);
    chk("rst_op1", out_op1, 64'd0);
    chk("rst_uop", out_uop[63:0], 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    #9 rstn = 1'b1;
    tick();

    // Preload r5, r7 (old value), r3
    wbset(0, 1'b1, 5'd5, 32'h1234); wbset(1, 1'b1, 5'd7, 32'h77);
    tick();
    wbset(0, 1'b1, 5'd3, 32'h33); wbset(1, 1'b0, 5'd0, 32'h0);
    tick();
    wb_en = 2'b00;

    // Basic RF read of r5
    set_lane(0, 1'b1, 5'd5, 5'd0, 2'd0, 2'd1, 32'h100, 32'h10, 64'h1111);
    set_lane(1, 1'b0, 5'd0, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0, 64'h0);
    push(2'b01, 64'h1111, 32'h1234, 32'h10, 32'h0, 32'h0);
    issue();

    // Same-cycle double write to r7, read in capture cycle
    wbset(0, 1'b1, 5'd7, 32'hA); wbset(1, 1'b1, 5'd7, 32'hB);
    set_lane(0, 1'b1, 5'd0, 5'd0, 2'd1, 2'd2, 32'h400, 32'h0, 64'h2222);
    set_lane(1, 1'b1, 5'd0, 5'd7, 2'd2, 2'd0, 32'h0, 32'h0, 64'h2);
    push(2'b11, 64'h2222, 32'h400, 32'h2, 32'h0, exp_r7_op2);
    issue();
    wb_en = 2'b00;
    set_lane(0, 1'b1, 5'd0, 5'd7, 2'd2, 2'd0, 32'h0, 32'h0, 64'h3333);
    set_lane(1, 1'b0, 5'd0, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0, 64'h3);
    push(2'b01, 64'h3333, 32'h0, 32'hB, 32'h0, 32'h0);
    issue();

    // Counter and immediate selects
    set_lane(0, 1'b1, 5'd0, 5'd0, 2'd3, 2'd2, 32'h0, 32'h0, 64'h4444);
    set_lane(1, 1'b1, 5'd0, 5'd0, 2'd1, 2'd3, 32'h800, 32'h0, 64'h4);
    push(2'b11, 64'h4444, 32'h0, 32'h2, 32'h800, 32'h9);
    issue();
    set_lane(0, 1'b1, 5'd5, 5'd0, 2'd0, 2'd1, 32'h0, 32'h7, 64'h5555);
    set_lane(1, 1'b1, 5'd0, 5'd0, 2'd2, 2'd1, 32'h0, 32'hFFF, 64'h5);
    push(2'b11, 64'h5555, 32'h1234, 32'h7, 32'h0, 32'hFFF);
    issue();

    // r0: write ignored, reads zero (also with a concurrent write to r0)
    wbset(0, 1'b1, 5'd0, 32'hDEAD);
    set_lane(0, 1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0, 64'h6666);
    set_lane(1, 1'b1, 5'd0, 5'd5, 2'd0, 2'd0, 32'h0, 32'h0, 64'h6);
    push(2'b11, 64'h6666, 32'h0, 32'h0, 32'h0, 32'h1234);
    issue();
    wb_en = 2'b00;
    set_lane(0, 1'b1, 5'd0, 5'd0, 2'd0, 2'd1, 32'h0, 32'h0, 64'h7777);
    set_lane(1, 1'b0, 5'd0, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0, 64'h7);
    push(2'b01, 64'h7777, 32'h0, 32'h0, 32'h0, 32'h0);
    issue();
    tick(); tick();

    // Hold refresh while stalled: port1 wins over port0 on r3; imm operand untouched
    out_ready = 1'b0;
    set_lane(0, 1'b1, 5'd3, 5'd3, 2'd0, 2'd1, 32'h0, 32'h1, 64'h8888);
    set_lane(1, 1'b1, 5'd0, 5'd3, 2'd2, 2'd1, 32'h0, 32'h3, 64'h8);
    push(2'b11, 64'h8888, 32'h55, 32'h1, 32'h0, 32'h3);
    issue();
    wbset(0, 1'b1, 5'd3, 32'h44); wbset(1, 1'b1, 5'd3, 32'h55);
    tick();
    wb_en = 2'b00;
    chk("hold_valid", {63'd0, out_valid}, 64'd1);
    chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    chk("hold_op1_refresh", {32'd0, out_op1[31:0]}, 64'h55);
    chk("hold_op2_l1_imm", {32'd0, out_op2[63:32]}, 64'h3);
    tick(); tick();
    chk("hold_stable", {32'd0, out_op1[31:0]}, 64'h55);
    out_ready = 1'b1;
    tick();
    chk("release_once", {63'd0, out_valid}, 64'd0);
    tick();

    // Flush with an offered bundle while stalled
    out_ready = 1'b0;
    set_lane(0, 1'b1, 5'd5, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0, 64'h9999);
    issue();
    set_lane(0, 1'b1, 5'd5, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0, 64'hAAAA);
    in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready_after", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    tick(); tick();

    // Asynchronous reset mid-stall
    out_ready = 1'b0;
    set_lane(0, 1'b1, 5'd5, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0, 64'hBBBB);
    issue();
    chk("stall_valid", {63'd0, out_valid}, 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_lane_en", {62'd0, out_lane_en}, 64'd0);
    chk("arst_op1", out_op1, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    #2 rstn = 1'b1;
    out_ready = 1'b1;

    // Array contents survive reset
    set_lane(0, 1'b1, 5'd5, 5'd0, 2'd0, 2'd2, 32'h0, 32'h0, 64'hCCCC);
    set_lane(1, 1'b0, 5'd0, 5'd0, 2'd0, 2'd0, 32'h0, 32'h0, 64'hC);
    push(2'b01, 64'hCCCC, 32'h1234, 32'h2, 32'h0, 32'h0);
    issue();
    tick(); tick(); tick();

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
